// File: rtl/hazard_sequencer.sv
// hazard_sequencer: merges load-use, branch redirect, mul/div occupancy and
// syscall halt requests into per-stage freeze/bubble/flush controls for the
// 5-stage pipeline, and keeps saturating stall and flush counters.
module hazard_sequencer #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_id_ex,
    input  logic        RegWrite_id_ex,
    input  logic [4:0]  regfile_write_num_id_ex,
    input  logic [4:0]  regfile_read_num1_id,
    input  logic [4:0]  regfile_read_num2_id,
    input  logic        branch_taken_ex,
    input  logic        md_start,
    input  logic        halt_req,
    input  logic        resume,
    input  logic        counter_clear,
    output logic        freeze_pc,
    output logic        freeze_if_id,
    output logic        freeze_id_ex,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic        bubble_ex_mem,
    output logic        md_result_valid,
    output logic        halted,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;

    // md_start itself is the first frozen cycle, so MD_WAIT only needs
    // MD_CYCLES-1 further frozen cycles before the result cycle.
    localparam logic [7:0]  MD_LOAD = 8'(MD_CYCLES - 1);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_t      state_reg;
    state_t      state_next;
    logic [7:0]  md_cnt_reg;
    logic [7:0]  md_cnt_next;
    logic        halt_pending_reg;
    logic        halt_pending_next;
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;
    logic        load_use;

    // A load in EX whose destination feeds the instruction in ID; r0 never hazards.
    assign load_use = MemRead_id_ex & RegWrite_id_ex &
                      (regfile_write_num_id_ex != 5'd0) &
                      ((regfile_write_num_id_ex == regfile_read_num1_id) |
                       (regfile_write_num_id_ex == regfile_read_num2_id));

    // Mealy control outputs and next-state selection, forced quiet during reset.
    always_comb begin
        freeze_pc         = 1'b0;
        freeze_if_id      = 1'b0;
        freeze_id_ex      = 1'b0;
        flush_if_id       = 1'b0;
        bubble_id_ex      = 1'b0;
        bubble_ex_mem     = 1'b0;
        md_result_valid   = 1'b0;
        halted            = 1'b0;
        state_next        = state_reg;
        md_cnt_next       = md_cnt_reg;
        halt_pending_next = halt_pending_reg;

        case (state_reg)
            RUN: begin
                if (halt_req) begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    bubble_id_ex = 1'b1;
                    state_next   = HALT;
                end else if (md_start) begin
                    freeze_pc     = 1'b1;
                    freeze_if_id  = 1'b1;
                    freeze_id_ex  = 1'b1;
                    bubble_ex_mem = 1'b1;
                    md_cnt_next   = MD_LOAD;
                    state_next    = MD_WAIT;
                end else if (branch_taken_ex) begin
                    // Flushing IF/ID also discards any load-use consumer in ID.
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                end else if (load_use) begin
                    freeze_pc    = 1'b1;
                    freeze_if_id = 1'b1;
                    bubble_id_ex = 1'b1;
                end
            end
            MD_WAIT: begin
                if (md_cnt_reg != 8'd0) begin
                    freeze_pc     = 1'b1;
                    freeze_if_id  = 1'b1;
                    freeze_id_ex  = 1'b1;
                    bubble_ex_mem = 1'b1;
                    md_cnt_next   = md_cnt_reg - 8'd1;
                    if (halt_req) begin
                        halt_pending_next = 1'b1;
                    end
                end else begin
                    // Result cycle: a halt seen anywhere in MD_WAIT (including now)
                    // is taken once the result has been latched.
                    md_result_valid   = 1'b1;
                    state_next        = (halt_pending_reg | halt_req) ? HALT : RUN;
                    halt_pending_next = 1'b0;
                end
            end
            HALT: begin
                freeze_pc    = 1'b1;
                freeze_if_id = 1'b1;
                bubble_id_ex = 1'b1;
                halted       = 1'b1;
                if (resume) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (rst) begin
            freeze_pc       = 1'b0;
            freeze_if_id    = 1'b0;
            freeze_id_ex    = 1'b0;
            flush_if_id     = 1'b0;
            bubble_id_ex    = 1'b0;
            bubble_ex_mem   = 1'b0;
            md_result_valid = 1'b0;
            halted          = 1'b0;
        end
    end

    // Sequencer state, mul/div countdown and deferred halt flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= RUN;
            md_cnt_reg       <= 8'd0;
            halt_pending_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            md_cnt_reg       <= md_cnt_next;
            halt_pending_reg <= halt_pending_next;
        end
    end

    // Saturating stall counter; clear takes precedence over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= 32'd0;
        end else if (counter_clear) begin
            stall_cycles_reg <= 32'd0;
        end else if (freeze_pc && (stall_cycles_reg != CNT_MAX)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    // Saturating flush counter; clear takes precedence over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count_reg <= 32'd0;
        end else if (counter_clear) begin
            flush_count_reg <= 32'd0;
        end else if (flush_if_id && (flush_count_reg != CNT_MAX)) begin
            flush_count_reg <= flush_count_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios with constant
// expectations plus a randomized run against a cycle-level reference model.
module tb_hazard_sequencer;

    localparam int MD_CYCLES = 4;
    localparam longint CNT_MAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_id_ex;
    logic        RegWrite_id_ex;
    logic [4:0]  regfile_write_num_id_ex;
    logic [4:0]  regfile_read_num1_id;
    logic [4:0]  regfile_read_num2_id;
    logic        branch_taken_ex;
    logic        md_start;
    logic        halt_req;
    logic        resume;
    logic        counter_clear;
    logic        freeze_pc;
    logic        freeze_if_id;
    logic        freeze_id_ex;
    logic        flush_if_id;
    logic        bubble_id_ex;
    logic        bubble_ex_mem;
    logic        md_result_valid;
    logic        halted;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    hazard_sequencer #(.MD_CYCLES(MD_CYCLES)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .MemRead_id_ex           (MemRead_id_ex),
        .RegWrite_id_ex          (RegWrite_id_ex),
        .regfile_write_num_id_ex (regfile_write_num_id_ex),
        .regfile_read_num1_id    (regfile_read_num1_id),
        .regfile_read_num2_id    (regfile_read_num2_id),
        .branch_taken_ex         (branch_taken_ex),
        .md_start                (md_start),
        .halt_req                (halt_req),
        .resume                  (resume),
        .counter_clear           (counter_clear),
        .freeze_pc               (freeze_pc),
        .freeze_if_id            (freeze_if_id),
        .freeze_id_ex            (freeze_id_ex),
        .flush_if_id             (flush_if_id),
        .bubble_id_ex            (bubble_id_ex),
        .bubble_ex_mem           (bubble_ex_mem),
        .md_result_valid         (md_result_valid),
        .halted                  (halted),
        .stall_cycles            (stall_cycles),
        .flush_count             (flush_count)
    );

    always #5 clk = ~clk;

    // Control bundle order: fp, fi, fide, flush, bide, bexm, valid, halted
    logic [7:0] ctrl;
    assign ctrl = {freeze_pc, freeze_if_id, freeze_id_ex, flush_if_id,
                   bubble_id_ex, bubble_ex_mem, md_result_valid, halted};

    // Reference model: what the pipeline is doing (running, waiting on the
    // multiplier with a number of frozen cycles left, or halted).
    localparam int M_RUN = 0, M_MD = 1, M_HALT = 2;
    int     m_mode;
    int     m_frozen_left;
    bit     m_halt_wanted;
    longint m_stall;
    longint m_flush;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_id_ex = 0; RegWrite_id_ex = 0; regfile_write_num_id_ex = 0;
        regfile_read_num1_id = 0; regfile_read_num2_id = 0; branch_taken_ex = 0;
        md_start = 0; halt_req = 0; resume = 0; counter_clear = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_counters();
        counter_clear = 1'b1;
        tick();
        counter_clear = 1'b0;
    endtask

    function automatic logic [7:0] model_ctrl();
        bit hazard;
        hazard = MemRead_id_ex && RegWrite_id_ex && regfile_write_num_id_ex != 0 &&
                 (regfile_write_num_id_ex == regfile_read_num1_id ||
                  regfile_write_num_id_ex == regfile_read_num2_id);
        if (m_mode == M_HALT) return 8'b1100_1001;
        if (m_mode == M_MD)   return (m_frozen_left > 0) ? 8'b1110_0100 : 8'b0000_0010;
        if (halt_req)         return 8'b1100_1000;
        if (md_start)         return 8'b1110_0100;
        if (branch_taken_ex)  return 8'b0001_1000;
        if (hazard)           return 8'b1100_1000;
        return 8'b0000_0000;
    endfunction

    task automatic model_advance(input logic [7:0] e);
        if (counter_clear) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e[7]) m_stall = (m_stall >= CNT_MAX) ? CNT_MAX : m_stall + 1;
            if (e[4]) m_flush = (m_flush >= CNT_MAX) ? CNT_MAX : m_flush + 1;
        end
        case (m_mode)
            M_RUN: begin
                if (halt_req) m_mode = M_HALT;
                else if (md_start) begin
                    m_mode = M_MD;
                    m_frozen_left = MD_CYCLES - 1;
                    m_halt_wanted = 0;
                end
            end
            M_MD: begin
                if (halt_req) m_halt_wanted = 1;
                if (m_frozen_left > 0) m_frozen_left--;
                else begin
                    m_mode = m_halt_wanted ? M_HALT : M_RUN;
                    m_halt_wanted = 0;
                end
            end
            default: if (resume) m_mode = M_RUN;
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        halt_req = 1; md_start = 1; branch_taken_ex = 1;
        #2;
        checks++;
        if (ctrl !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %b expected %b", ctrl, 8'h00);
        end
        tick();
        tick();
        checks++;
        if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_count);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        checks++;
        if (ctrl !== 8'h00) begin
            errors++; $display("FAIL reset_idle_run: got %b expected %b", ctrl, 8'h00);
        end
        $display("txn reset: ctrl=%b stall=%0d flush=%0d", ctrl, stall_cycles, flush_count);
    endtask

    task automatic test_load_use();
        clear_counters();
        MemRead_id_ex = 1; RegWrite_id_ex = 1; regfile_write_num_id_ex = 5;
        regfile_read_num1_id = 7; regfile_read_num2_id = 5;
        #1;
        checks++;
        if (ctrl !== 8'b1100_1000) begin
            errors++; $display("FAIL load_use_stall: got %b expected %b", ctrl, 8'b1100_1000);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (freeze_pc !== 1'b0 || stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_count: got fp=%b stall=%0d expected fp=0 stall=1", freeze_pc, stall_cycles);
        end
        MemRead_id_ex = 1; RegWrite_id_ex = 1; regfile_write_num_id_ex = 0;
        regfile_read_num1_id = 0; regfile_read_num2_id = 0;
        #1;
        checks++;
        if (ctrl !== 8'h00) begin
            errors++; $display("FAIL load_use_r0: got %b expected %b", ctrl, 8'h00);
        end
        tick();
        idle_inputs();
        checks++;
        if (stall_cycles !== 32'd1) begin
            errors++; $display("FAIL load_use_r0_count: got %0d expected 1", stall_cycles);
        end
        $display("txn load_use: stall=%0d", stall_cycles);
    endtask

    task automatic test_branch_vs_load_use();
        clear_counters();
        MemRead_id_ex = 1; RegWrite_id_ex = 1; regfile_write_num_id_ex = 9;
        regfile_read_num1_id = 9; branch_taken_ex = 1;
        #1;
        checks++;
        if (ctrl !== 8'b0001_1000) begin
            errors++; $display("FAIL branch_priority: got %b expected %b", ctrl, 8'b0001_1000);
        end
        tick();
        idle_inputs();
        checks++;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1/0", flush_count, stall_cycles);
        end
        $display("txn branch_vs_load_use: flush=%0d stall=%0d", flush_count, stall_cycles);
    endtask

    task automatic test_muldiv();
        clear_counters();
        md_start = 1;
        #1;
        checks++;
        if (ctrl !== 8'b1110_0100) begin
            errors++; $display("FAIL md_start_cycle: got %b expected %b", ctrl, 8'b1110_0100);
        end
        tick();
        md_start = 0;
        branch_taken_ex = 1;   // must be ignored while waiting
        for (int i = 0; i < MD_CYCLES - 1; i++) begin
            #1;
            checks++;
            if (ctrl !== 8'b1110_0100) begin
                errors++; $display("FAIL md_wait_%0d: got %b expected %b", i, ctrl, 8'b1110_0100);
            end
            tick();
        end
        branch_taken_ex = 0;
        #1;
        checks++;
        if (ctrl !== 8'b0000_0010) begin
            errors++; $display("FAIL md_result: got %b expected %b", ctrl, 8'b0000_0010);
        end
        tick();
        checks++;
        if (ctrl !== 8'h00 || stall_cycles !== 32'd4) begin
            errors++; $display("FAIL md_done: got ctrl=%b stall=%0d expected 00000000/4", ctrl, stall_cycles);
        end
        $display("txn muldiv: stall=%0d", stall_cycles);
    endtask

    task automatic test_halt_during_md();
        md_start = 1;
        tick();
        md_start = 0;
        tick();              // 1st MD_WAIT cycle
        halt_req = 1;        // 2nd MD_WAIT cycle
        tick();
        halt_req = 0;
        tick();              // 3rd MD_WAIT cycle
        checks++;
        if (ctrl !== 8'b0000_0010) begin
            errors++; $display("FAIL halt_md_result: got %b expected %b", ctrl, 8'b0000_0010);
        end
        tick();
        checks++;
        if (ctrl !== 8'b1100_1001) begin
            errors++; $display("FAIL halt_md_halted: got %b expected %b", ctrl, 8'b1100_1001);
        end
        tick();
        resume = 1;
        #1;
        checks++;
        if (ctrl !== 8'b1100_1001) begin
            errors++; $display("FAIL halt_resume_cycle: got %b expected %b", ctrl, 8'b1100_1001);
        end
        tick();
        resume = 0;
        checks++;
        if (ctrl !== 8'h00) begin
            errors++; $display("FAIL halt_back_to_run: got %b expected %b", ctrl, 8'h00);
        end
        $display("txn halt_during_md: ctrl=%b", ctrl);
    endtask

    task automatic test_reset_mid_md();
        md_start = 1;
        tick();
        md_start = 0;
        tick();              // md_cnt now 2, still frozen
        checks++;
        if (freeze_pc !== 1'b1) begin
            errors++; $display("FAIL rst_mid_precheck: got fp=%b expected 1", freeze_pc);
        end
        rst = 1;
        #1;
        checks++;
        if (ctrl !== 8'h00 || stall_cycles !== 32'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got ctrl=%b stall=%0d expected 00000000/0", ctrl, stall_cycles);
        end
        tick();
        rst = 0;
        #1;
        checks++;
        if (ctrl !== 8'h00 || stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
            errors++; $display("FAIL rst_mid_release: got ctrl=%b stall=%0d flush=%0d expected 0", ctrl, stall_cycles, flush_count);
        end
        tick();
        $display("txn reset_mid_md: ctrl=%b", ctrl);
    endtask

    task automatic test_saturation();
        force dut.stall_cycles_reg = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_reg;
        MemRead_id_ex = 1; RegWrite_id_ex = 1; regfile_write_num_id_ex = 3;
        regfile_read_num1_id = 3;
        tick();
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_reach: got %h expected ffffffff", stall_cycles);
        end
        tick();
        tick();
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cycles);
        end
        counter_clear = 1;
        tick();
        counter_clear = 0;
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++; $display("FAIL sat_clear: got %h expected 0", stall_cycles);
        end
        idle_inputs();
        tick();
        $display("txn saturation: stall=%0d", stall_cycles);
    endtask

    task automatic test_random();
        logic [7:0] e;
        apply_reset();
        m_mode = M_RUN; m_frozen_left = 0; m_halt_wanted = 0; m_stall = 0; m_flush = 0;
        for (int n = 0; n < 400; n++) begin
            MemRead_id_ex           = ($urandom_range(99) < 50);
            RegWrite_id_ex          = ($urandom_range(99) < 70);
            regfile_write_num_id_ex = 5'($urandom_range(3));
            regfile_read_num1_id    = 5'($urandom_range(3));
            regfile_read_num2_id    = 5'($urandom_range(3));
            branch_taken_ex         = ($urandom_range(99) < 20);
            md_start                = ($urandom_range(99) < 10);
            halt_req                = ($urandom_range(99) < 5);
            resume                  = ($urandom_range(99) < 30);
            counter_clear           = ($urandom_range(99) < 2);
            #1;
            e = model_ctrl();
            checks++;
            if (ctrl !== e) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got %b expected %b", n, ctrl, e);
            end
            checks++;
            if (stall_cycles !== 32'(m_stall) || flush_count !== 32'(m_flush)) begin
                errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d expected %0d/%0d",
                                   n, stall_cycles, flush_count, m_stall, m_flush);
            end
            $display("txn rand %0d: ctrl=%b stall=%0d flush=%0d", n, ctrl, stall_cycles, flush_count);
            model_advance(e);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_load_use();
        test_muldiv();
        test_halt_during_md();
        test_reset_mid_md();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard and stall sequencer for the 5-stage MIPS core. It merges the load-use hazard, EX-stage branch redirects, the multi-cycle multiply/divide unit and syscall halt requests into one prioritized set of per-stage freeze, bubble and flush controls. It also keeps saturating stall and flush performance counters. It sits beside the ID/EX pipeline registers and drives the PC, IF/ID, ID/EX and EX/MEM register enables.

## Interface
- MD_CYCLES, 4: multiply/divide EX occupancy in stall cycles; legal range 2..255.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MemRead_id_ex  in  1  instruction in EX is a load.
- RegWrite_id_ex  in  1  instruction in EX writes the register file.
- regfile_write_num_id_ex  in  5  destination register of the instruction in EX.
- regfile_read_num1_id, regfile_read_num2_id  in  5  source registers of the instruction in ID.
- branch_taken_ex  in  1  branch/jump in EX redirects the PC this cycle.
- md_start  in  1  mul/div instruction is in EX this cycle (RUN state only).
- halt_req  in  1  syscall halt decoded in ID.
- resume  in  1  leave HALT.
- counter_clear  in  1  synchronous clear of both counters.
- freeze_pc, freeze_if_id, freeze_id_ex  out  1  hold the respective register.
- flush_if_id  out  1  overwrite IF/ID with a nop.
- bubble_id_ex, bubble_ex_mem  out  1  insert a nop into the respective register.
- md_result_valid  out  1  mul/div result is latched by EX/MEM this cycle.
- halted  out  1  state == HALT.
- stall_cycles  out  32  count of cycles with freeze_pc=1, saturating.
- flush_count  out  32  count of cycles with flush_if_id=1, saturating.

## Operation
- States: RUN, MD_WAIT, HALT. Internal: 8-bit md_cnt and 1-bit halt_pending.
- Control outputs are Mealy outputs: combinational from state and current inputs. Every output not listed for a case is 0.
- load_use = MemRead_id_ex & RegWrite_id_ex & (regfile_write_num_id_ex != 0) & (regfile_write_num_id_ex matches read_num1 or read_num2).
- RUN cases are mutually exclusive, in this priority order:
  1. halt_req: freeze_pc, freeze_if_id, bubble_id_ex. Next state HALT.
  2. md_start: freeze_pc, freeze_if_id, freeze_id_ex, bubble_ex_mem. md_cnt <= MD_CYCLES-1. Next state MD_WAIT.
  3. branch_taken_ex: flush_if_id, bubble_id_ex. Stay in RUN. This also kills any load-use consumer in ID.
  4. load_use: freeze_pc, freeze_if_id, bubble_id_ex for exactly one cycle. No state change; the hazard clears naturally once the load leaves EX.
- MD_WAIT:
  - While md_cnt != 0: same four freeze/bubble outputs as the md_start case; md_cnt decrements.
  - When md_cnt == 0: all freezes released and md_result_valid=1. Next state is HALT if halt_pending, else RUN; halt_pending is cleared.
  - halt_req seen in any MD_WAIT cycle sets halt_pending. branch_taken_ex, load_use and md_start are ignored in MD_WAIT.
- HALT:
  - Outputs: freeze_pc, freeze_if_id, bubble_id_ex, halted.
  - resume=1 goes to RUN at the next edge; outputs stay stalled during the resume cycle.
  - halt_req is ignored in HALT.
- Counters:
  - stall_cycles increments on every edge where freeze_pc=1.
  - flush_count increments on every edge where flush_if_id=1.
  - Both hold at 32'hFFFF_FFFF.
  - counter_clear zeroes both and wins over a same-cycle increment.

## Timing
- Reset (asynchronous): state RUN, md_cnt 0, halt_pending 0, both counters 0.
  - While rst=1, every control output, halted and md_result_valid is forced to 0.
  - Reset during MD_WAIT or HALT abandons the operation; the first cycle after deassertion is RUN.
- Load-use costs 1 stall cycle. A branch costs 2 flushed slots (IF/ID and ID/EX) and 0 stall cycles.
- Mul/div cycle accounting:
  - freeze_pc is high for MD_CYCLES consecutive cycles: the md_start cycle plus MD_CYCLES-1 MD_WAIT cycles.
  - md_result_valid goes high in cycle MD_CYCLES+1 counted from md_start, with no freezes in that cycle.
- A halt_req arriving during MD_WAIT takes effect on the cycle after the md_result_valid cycle.
- Counter outputs are registered and reflect events up to the previous edge.

## Test plan
- Load-use: RUN, MemRead=RegWrite=1, write_num=5, read_num2=5 for 1 cycle -> freeze_pc, freeze_if_id, bubble_id_ex high for 1 cycle; stall_cycles=1. Same stimulus with write_num=0 -> no stall.
- Branch vs load-use: branch_taken_ex and load_use in the same cycle -> flush_if_id=1, bubble_id_ex=1, freeze_pc=0; flush_count=1, stall_cycles=0.
- Mul/div, MD_CYCLES=4: md_start pulse -> freeze_pc high 4 cycles; md_result_valid=1 on cycle 5; stall_cycles=4; state back to RUN.
- Halt during mul/div: halt_req in the 2nd MD_WAIT cycle -> md_result_valid on schedule, then halted=1 next cycle. resume one cycle later -> RUN on the following edge.
- Reset mid-operation: rst asserted in MD_WAIT with md_cnt=2 -> all outputs 0 immediately; after release, state RUN and counters 0.
- Counter saturation: force stall_cycles to 32'hFFFF_FFFE, stall 3 cycles -> holds at 32'hFFFF_FFFF. counter_clear together with a stall -> 0.
